// File: rtl/uart_rx_io_driver.sv
// UART 8N1 receiver with a small receive FIFO behind an MMIO read port.
// DATA (addr 0) pops the head byte, STATUS (addr 2) reports and clears flags.
module uart_rx_io_driver #(
   parameter int CLKS_PER_BIT = 2604,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        iCpuClock,
   input  logic        iCpuReset,
   input  logic        iUartFromPc,
   input  logic        iUartCtrl,
   input  logic        iIoRead,
   input  logic [1:0]  iUartAddress,
   output logic [15:0] oUartData,
   output logic        oRxNotEmpty
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   localparam logic [15:0] LAST_C = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_C = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } rx_state_t;

   rx_state_t state;

   logic        rx_meta;
   logic        rx_sync;
   logic [15:0] baud_cnt;
   logic [2:0]  bit_cnt;
   logic [7:0]  shift_reg;

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             overrun;
   logic             frame_err;

   logic stop_hit;
   logic push_req;
   logic frame_bad;
   logic not_empty;
   logic full;
   logic data_rd;
   logic status_rd;
   logic pop;
   logic push_ok;
   logic ovr_set;
   logic [7:0] head_byte;

   // Two-flop synchronizer for the asynchronous serial line (idles high).
   always_ff @(posedge iCpuClock) begin
      if (iCpuReset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= iUartFromPc;
         rx_sync <= rx_meta;
      end
   end

   // Receive FSM: find start edge, confirm mid-start, sample mid-bit.
   always_ff @(posedge iCpuClock) begin
      if (iCpuReset) begin
         state     <= S_IDLE;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               baud_cnt <= '0;
               bit_cnt  <= '0;
               if (!rx_sync) begin
                  state <= S_START;
               end
            end
            S_START: begin
               if (baud_cnt == HALF_C) begin
                  baud_cnt <= '0;
                  state    <= rx_sync ? S_IDLE : S_DATA;
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            S_DATA: begin
               if (baud_cnt == LAST_C) begin
                  baud_cnt           <= '0;
                  shift_reg[bit_cnt] <= rx_sync;
                  if (bit_cnt == 3'd7) begin
                     bit_cnt <= '0;
                     state   <= S_STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            S_STOP: begin
               if (baud_cnt == LAST_C) begin
                  baud_cnt <= '0;
                  state    <= S_IDLE;
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // The stop sample decides the frame on the same edge the FSM leaves STOP.
   assign stop_hit  = (state == S_STOP) && (baud_cnt == LAST_C);
   assign push_req  = stop_hit && rx_sync;
   assign frame_bad = stop_hit && !rx_sync;

   assign not_empty = (count != '0);
   assign full      = (count == DEPTH_C);

   assign data_rd   = iUartCtrl && iIoRead && (iUartAddress == 2'd0);
   assign status_rd = iUartCtrl && iIoRead && (iUartAddress == 2'd2);

   // A pop frees the head slot this edge, so a full FIFO can still accept.
   assign pop     = data_rd && not_empty;
   assign push_ok = push_req && (!full || pop);
   assign ovr_set = push_req && full && !pop;

   assign head_byte = not_empty ? mem[rd_ptr] : 8'h00;

   // FIFO storage; contents need no reset since count gates every read.
   always_ff @(posedge iCpuClock) begin
      if (push_ok) begin
         mem[wr_ptr] <= shift_reg;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge iCpuClock) begin
      if (iCpuReset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         unique case ({push_ok, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Sticky error flags: a STATUS read clears, a same-cycle event wins.
   always_ff @(posedge iCpuClock) begin
      if (iCpuReset) begin
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (ovr_set) begin
            overrun <= 1'b1;
         end else if (status_rd) begin
            overrun <= 1'b0;
         end
         if (frame_bad) begin
            frame_err <= 1'b1;
         end else if (status_rd) begin
            frame_err <= 1'b0;
         end
      end
   end

   // Read mux; drives zero when not selected so the bus can be ORed.
   always_comb begin
      oUartData = 16'h0000;
      unique case (1'b1)
         data_rd:   oUartData = {8'h00, head_byte};
         status_rd: oUartData = {12'h000, frame_err, overrun, full, not_empty};
         default:   oUartData = 16'h0000;
      endcase
   end

   assign oRxNotEmpty = not_empty;

endmodule

// File: tb/tb_uart_rx_io_driver.sv
// Scoreboard bench for uart_rx_io_driver (CLKS_PER_BIT=16, FIFO_DEPTH=4).
// Reads push expectations; a negedge monitor pops and compares.
module tb_uart_rx_io_driver;

   localparam int CPB = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx = 1'b1;
   logic        ctrl = 1'b0;
   logic        iord = 1'b0;
   logic [1:0]  addr = 2'd0;
   logic [15:0] data;
   logic        ne;

   typedef struct {
      string       name;
      logic [15:0] d;
      logic        ne;
   } exp_t;

   exp_t sb[$];
   int   passed = 0;
   int   total = 0;

   always #5 clk = ~clk;

   uart_rx_io_driver #(
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH(4)
   ) dut (
      .iCpuClock(clk),
      .iCpuReset(rst),
      .iUartFromPc(rx),
      .iUartCtrl(ctrl),
      .iIoRead(iord),
      .iUartAddress(addr),
      .oUartData(data),
      .oRxNotEmpty(ne)
   );

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] exp);
      total++;
      if (act === exp) begin
         passed++;
      end else begin
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: compare every read cycle against the scoreboard head.
   exp_t mon_e;
   always @(negedge clk) begin
      if (ctrl && iord) begin
         if (sb.size() == 0) begin
            total++;
            $display("FAIL sb_unexpected: got %h expected none", data);
         end else begin
            mon_e = sb.pop_front();
            chk(mon_e.name, data, mon_e.d);
            chk({mon_e.name, "_ne"}, {15'b0, ne}, {15'b0, mon_e.ne});
         end
      end else begin
         chk("idle_bus", data, 16'h0000);
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [1:0] a, input logic [15:0] d,
                     input logic n, input string nm);
      exp_t e;
      e.name = nm;
      e.d    = d;
      e.ne   = n;
      sb.push_back(e);
      ctrl = 1'b1;
      iord = 1'b1;
      addr = a;
      idle(1);
      ctrl = 1'b0;
      iord = 1'b0;
      addr = 2'd0;
   endtask

   task automatic send(input logic [7:0] b, input logic stop);
      logic [9:0] frame;
      frame = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = frame[i];
         idle(CPB);
      end
      rx = 1'b1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle(3);
      rst = 1'b0;
      idle(4);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      #1;
      do_reset();

      // reset state
      rd(2'd2, 16'h0000, 1'b0, "rst_status");
      rd(2'd0, 16'h0000, 1'b0, "rst_data");
      rd(2'd1, 16'h0000, 1'b0, "rst_rsvd1");

      // single byte
      send(8'hA5, 1'b1);
      idle(4);
      ctrl = 1'b1;
      idle(1);
      ctrl = 1'b0;
      rd(2'd2, 16'h0001, 1'b1, "a5_status");
      rd(2'd0, 16'h00A5, 1'b1, "a5_data");
      rd(2'd2, 16'h0000, 1'b0, "a5_status2");

      // start-bit glitch
      rx = 1'b0;
      idle(5);
      rx = 1'b1;
      idle(40);
      rd(2'd2, 16'h0000, 1'b0, "glitch_status");

      // overrun
      for (int b = 1; b <= 5; b++) begin
         send(8'(b), 1'b1);
         idle(32);
      end
      rd(2'd3, 16'h0000, 1'b1, "ovr_rsvd3");
      rd(2'd2, 16'h0007, 1'b1, "ovr_status");
      rd(2'd2, 16'h0003, 1'b1, "ovr_status2");
      rd(2'd0, 16'h0001, 1'b1, "ovr_d1");
      rd(2'd0, 16'h0002, 1'b1, "ovr_d2");
      rd(2'd0, 16'h0003, 1'b1, "ovr_d3");
      rd(2'd0, 16'h0004, 1'b1, "ovr_d4");
      rd(2'd0, 16'h0000, 1'b0, "ovr_empty");
      rd(2'd2, 16'h0000, 1'b0, "ovr_status3");

      // simultaneous push and pop while full
      do_reset();
      for (int b = 1; b <= 4; b++) begin
         send(8'(b), 1'b1);
         idle(32);
      end
      rd(2'd2, 16'h0003, 1'b1, "sim_full");
      fork
         send(8'h05, 1'b1);
         begin
            idle(154);
            rd(2'd0, 16'h0001, 1'b1, "sim_pop");
         end
      join
      idle(20);
      rd(2'd2, 16'h0003, 1'b1, "sim_status");
      rd(2'd0, 16'h0002, 1'b1, "sim_d2");
      rd(2'd0, 16'h0003, 1'b1, "sim_d3");
      rd(2'd0, 16'h0004, 1'b1, "sim_d4");
      rd(2'd0, 16'h0005, 1'b1, "sim_d5");
      rd(2'd2, 16'h0000, 1'b0, "sim_status2");

      // framing error
      send(8'h3C, 1'b0);
      idle(40);
      rd(2'd2, 16'h0008, 1'b0, "fe_status");
      rd(2'd2, 16'h0000, 1'b0, "fe_status2");
      rd(2'd0, 16'h0000, 1'b0, "fe_data");

      // reset mid-frame
      fork
         send(8'h5A, 1'b1);
         begin
            idle(CPB * 5 + 4);
            rst = 1'b1;
         end
      join
      idle(2);
      rst = 1'b0;
      idle(8);
      send(8'h77, 1'b1);
      idle(20);
      rd(2'd2, 16'h0001, 1'b1, "mr_status");
      rd(2'd0, 16'h0077, 1'b1, "mr_data");
      rd(2'd2, 16'h0000, 1'b0, "mr_status2");

      idle(4);
      chk("sb_drain", 16'(sb.size()), 16'h0000);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
